// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//
// Purpose:
//   Instruction fetch front end. It issues sequential read requests to an
//   instruction memory with a fixed one-cycle read latency. Returned words
//   are queued together with their PC in a small FIFO, and the FIFO head is
//   presented to decode with a valid/ready handshake. A redirect (pc_src)
//   flushes the queue, squashes any in-flight response and restarts fetch
//   at an aligned branch target.
//
// Parameters:
//   WORD       address / PC width in bits
//   INSTR_LEN  instruction width in bits
//   STEP       PC increment per instruction (power of two)
//   DEPTH      queue entries (power of two, >= 2)
//   RESET_PC   fetch PC after reset
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   pc_src         in   redirect request (one-cycle pulse)
//   branch_target  in   redirect PC, sampled when pc_src=1
//   imem_req       out  instruction-memory read request
//   imem_addr      out  read address, valid with imem_req
//   imem_rdata     in   read data, valid one cycle after imem_req
//   instr_valid    out  queue head valid
//   instr_ready    in   decode accepts head
//   instruction    out  head instruction (0 while empty)
//   cur_pc         out  PC of head instruction (0 while empty)
//   incremented_pc out  cur_pc + STEP, wrapping (0 while empty)
//
// Optional build macro:
//   FETCH_PERF_EN  adds fetch_count (pushes) and squash_count (squashed
//                  in-flight responses plus flushed entries), both 32-bit
//                  saturating counters.
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int              WORD      = 64,
    parameter int              INSTR_LEN = 32,
    parameter int              STEP      = 4,
    parameter int              DEPTH     = 4,
    parameter logic [WORD-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_src,
    input  logic [WORD-1:0]      branch_target,
    output logic                 imem_req,
    output logic [WORD-1:0]      imem_addr,
    input  logic [INSTR_LEN-1:0] imem_rdata,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTR_LEN-1:0] instruction,
    output logic [WORD-1:0]      cur_pc,
    output logic [WORD-1:0]      incremented_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          fetch_count,
    output logic [31:0]          squash_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Low PC bits below the instruction step are always zero.
    localparam logic [WORD-1:0] ALIGN_MASK = WORD'(STEP - 1);

    // Architectural state
    logic [WORD-1:0] fetch_pc_reg;
    logic            inflight_reg;      // a request was issued last cycle
    logic [WORD-1:0] inflight_pc_reg;   // PC of that request
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;

    // Queue storage (not reset: emptiness is tracked by count_reg)
    logic [INSTR_LEN-1:0] instr_mem [DEPTH];
    logic [WORD-1:0]      pc_mem    [DEPTH];

    // Control
    logic [CW:0]     occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    logic            not_empty;
    logic [WORD-1:0] head_pc;

    always_comb begin
        // Queue entries plus the one response that may still be arriving;
        // keeping this below DEPTH is what guarantees a push is never dropped.
        occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
        // Gating with reset keeps imem_req low while reset is held.
        issue     = reset && !pc_src && (occupancy < (CW+1)'(DEPTH));
        not_empty = (count_reg != '0);
        // A redirect cycle hides the head so a flushed entry is never consumed.
        instr_valid = not_empty && !pc_src;
        pop         = instr_valid && instr_ready;
        push        = inflight_reg && !pc_src;

        imem_req  = issue;
        imem_addr = fetch_pc_reg;

        head_pc        = pc_mem[rd_ptr_reg];
        instruction    = '0;
        cur_pc         = '0;
        incremented_pc = '0;
        if (not_empty) begin
            instruction    = instr_mem[rd_ptr_reg];
            cur_pc         = head_pc;
            incremented_pc = head_pc + WORD'(STEP);
        end
    end

    // Control state, asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
        end else if (pc_src) begin
            // Flush dominates: queue cleared, pending response squashed.
            fetch_pc_reg <= branch_target & ~ALIGN_MASK;
            inflight_reg <= 1'b0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                fetch_pc_reg    <= fetch_pc_reg + WORD'(STEP);
                inflight_pc_reg <= fetch_pc_reg;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Queue write port
    always_ff @(posedge clk) begin
        if (reset && push) begin
            instr_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
        end
    end

`ifdef FETCH_PERF_EN
    logic [CW:0] squash_inc;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // On a redirect every queued entry and the arriving response are discarded.
    assign squash_inc = pc_src ? occupancy : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count  <= '0;
            squash_count <= '0;
        end else begin
            fetch_count  <= sat_add(fetch_count, {{CW{1'b0}}, push});
            squash_count <= sat_add(squash_count, squash_inc);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
//
// Directed bench for fetch_buffer (WORD=64, INSTR_LEN=32, STEP=4, DEPTH=4,
// RESET_PC=0x100). The instruction memory model returns addr[31:0]^0xA5A50000
// one cycle after a request and 0xDEADBEEF otherwise. Expected values are
// hand-derived constants. Inputs are driven 1 time unit after the rising edge
// and outputs are checked there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_src;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [63:0] cur_pc;
    logic [63:0] incremented_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] squash_count;
`endif

    int total = 0;
    int bad   = 0;

    int          req_count;
    logic [63:0] last_addr;

    fetch_buffer #(
        .WORD      (64),
        .INSTR_LEN (32),
        .STEP      (4),
        .DEPTH     (4),
        .RESET_PC  (64'h100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .cur_pc         (cur_pc),
        .incremented_pc (incremented_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .squash_count   (squash_count)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle latency instruction memory
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr[31:0] ^ 32'hA5A5_0000;
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    // Request monitor, cleared while reset is held
    always @(posedge clk) begin
        if (!reset) begin
            req_count <= 0;
            last_addr <= '0;
        end else if (imem_req) begin
            req_count <= req_count + 1;
            last_addr <= imem_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
        $display("check %-14s got=%h want=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        pc_src        = 1'b0;
        branch_target = '0;
        instr_ready   = 1'b1;
        imem_rdata    = 32'hDEAD_BEEF;

        // Reset state
        #2;
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_req",   64'(imem_req),    64'd0);
        chk("rst_instr", 64'(instruction), 64'd0);
        chk("rst_pc",    cur_pc,           64'd0);
        chk("rst_incpc", incremented_pc,   64'd0);

        // Streaming from RESET_PC with decode always ready
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;                 // cycle 0
        #1;
        chk("c0_req",  64'(imem_req), 64'd1);
        chk("c0_addr", imem_addr,     64'h100);
        step();                       // cycle 1
        chk("c1_valid", 64'(instr_valid), 64'd0);
        step();                       // cycle 2
        chk("c2_valid", 64'(instr_valid), 64'd1);
        chk("c2_pc",    cur_pc,           64'h100);
        chk("c2_incpc", incremented_pc,   64'h104);
        chk("c2_instr", 64'(instruction), 64'hA5A5_0100);
        step();                       // cycle 3
        chk("c3_pc",    cur_pc,           64'h104);
        chk("c3_incpc", incremented_pc,   64'h108);
        step();                       // cycle 4
        chk("c4_pc",    cur_pc,           64'h108);
        instr_ready = 1'b0;

        // Reset mid-stream with two entries queued and one in flight
        step();                       // cycle 5
        chk("mid_valid", 64'(instr_valid), 64'd1);
        chk("mid_req",   64'(imem_req),    64'd1);
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(instr_valid), 64'd0);
        chk("arst_req",   64'(imem_req),    64'd0);
        chk("arst_pc",    cur_pc,           64'd0);
        step();

        // Restart at RESET_PC with decode stalled for 10 cycles
        reset = 1'b1;                 // cycle 0
        #1;
        chk("rs_req",  64'(imem_req), 64'd1);
        chk("rs_addr", imem_addr,     64'h100);
        for (int i = 0; i < 10; i++) step();   // cycle 10
        chk("stall_nreq",  64'(req_count),   64'd4);
        chk("stall_last",  last_addr,        64'h10C);
        chk("stall_req",   64'(imem_req),    64'd0);
        chk("stall_valid", 64'(instr_valid), 64'd1);
        chk("stall_pc",    cur_pc,           64'h100);
        chk("stall_instr", 64'(instruction), 64'hA5A5_0100);

        // Drain in order with no bubble once refill starts
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin     // cycles 10..15
            chk($sformatf("drain%0d_v", k), 64'(instr_valid), 64'd1);
            chk($sformatf("drain%0d_pc", k), cur_pc, 64'h100 + 64'(4 * k));
            if (k < 5) step();
        end

        // Redirect while 3 entries are queued and 1 response is in flight
        instr_ready = 1'b0;
        step();                       // cycle 16
        chk("pre_pc", cur_pc, 64'h114);
        pc_src        = 1'b1;
        branch_target = 64'h2002;
        instr_ready   = 1'b1;
        #1;
        chk("rd_valid", 64'(instr_valid), 64'd0);
        chk("rd_req",   64'(imem_req),    64'd0);
        step();                       // cycle 17
        pc_src = 1'b0;
        #1;
        chk("rd1_valid", 64'(instr_valid), 64'd0);
        chk("rd1_req",   64'(imem_req),    64'd1);
        chk("rd1_addr",  imem_addr,        64'h2000);
`ifdef FETCH_PERF_EN
        chk("perf_squash", 64'(squash_count), 64'd4);
        chk("perf_fetch",  64'(fetch_count),  64'd8);
`endif
        step();                       // cycle 18
        chk("rd2_valid", 64'(instr_valid), 64'd0);
        step();                       // cycle 19
        chk("rd3_valid", 64'(instr_valid), 64'd1);
        chk("rd3_pc",    cur_pc,           64'h2000);
        chk("rd3_incpc", incremented_pc,   64'h2004);
        chk("rd3_instr", 64'(instruction), 64'hA5A5_2000);

        // Back-to-back redirects; the last one targets the top of memory
        pc_src        = 1'b1;
        branch_target = 64'h3000;
        step();                       // cycle 20
        branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("bb_valid", 64'(instr_valid), 64'd0);
        step();                       // cycle 21
        pc_src = 1'b0;
        #1;
        chk("bb_req",  64'(imem_req), 64'd1);
        chk("bb_addr", imem_addr,     64'hFFFF_FFFF_FFFF_FFFC);
        step();                       // cycle 22
        chk("wrap_addr", imem_addr, 64'h0);
        step();                       // cycle 23
        chk("wrap_valid", 64'(instr_valid), 64'd1);
        chk("wrap_pc",    cur_pc,           64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_incpc", incremented_pc,   64'h0);
        chk("wrap_instr", 64'(instruction), 64'h5A5A_FFFC);
        step();                       // cycle 24
        chk("wrap2_pc",    cur_pc,         64'h0);
        chk("wrap2_incpc", incremented_pc, 64'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
